// File: rtl/qspi_flash_rd.sv
// qspi_flash_rd -- SPI-flash read engine (mode 0, single-bit initiator).
//
// Sends a read command and a 24-bit address, then streams p_in_len data
// bytes out on a valid/ready byte interface. SCK half-period is G_CLKDIV
// clocks. All outputs are registered.
//
// Optional build macro: QSPI_FLASH_RD_FAST_EN selects FAST READ (0x0B)
// with 8 dummy SCK periods between the address and the data. Without it
// the engine issues plain READ (0x03) and has no dummy phase.
//
// Ports:
//   p_in_clk, p_in_rstn       clock, async active-low reset
//   p_in_start/addr/len       request; sampled only while p_out_busy=0
//   p_out_busy, p_out_done    transfer in progress / 1-cycle completion
//   p_out_rxd/_vld, p_in_rxd_rdy  received byte stream (valid/ready)
//   p_out_spi_cs_n/clk/mosi, p_in_spi_miso  flash pins
module qspi_flash_rd #(
    parameter int G_CLKDIV = 2,
    parameter int G_LEN_W  = 16
) (
    input  logic               p_in_clk,
    input  logic               p_in_rstn,
    input  logic               p_in_start,
    input  logic [23:0]        p_in_addr,
    input  logic [G_LEN_W-1:0] p_in_len,
    output logic               p_out_busy,
    output logic               p_out_done,
    output logic [7:0]         p_out_rxd,
    output logic               p_out_rxd_vld,
    input  logic               p_in_rxd_rdy,
    output logic               p_out_spi_cs_n,
    output logic               p_out_spi_clk,
    output logic               p_out_spi_mosi,
    input  logic               p_in_spi_miso
);

`ifdef QSPI_FLASH_RD_FAST_EN
    localparam logic [7:0] C_CMD = 8'h0B;
`else
    localparam logic [7:0] C_CMD = 8'h03;
`endif
    localparam int DW = (G_CLKDIV > 1) ? $clog2(G_CLKDIV) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_CS_SETUP, S_CMD, S_ADDR, S_DUMMY, S_DATA, S_CS_HOLD, S_GAP
    } state_t;

    state_t             state, state_nxt;
    logic [DW-1:0]      div_cnt;
    logic [4:0]         bit_cnt;
    logic [G_LEN_W-1:0] byte_cnt;
    logic [30:0]        tx_sh;     // command bits 6..0 + address; bit 7 goes straight to mosi
    logic [7:0]         rx_sh;
    logic               pend;      // completed byte parked in rx_sh, waiting for the output slot

    logic run, tick, in_shift, bit_end, last_bit, accept, byte_done, can_load;
    logic [7:0] rx_byte;

    always_comb begin
        // While a byte is parked the phase timer freezes, holding SCK low.
        run       = !pend;
        tick      = (state != S_IDLE) && run && (div_cnt == DW'(G_CLKDIV - 1));
        in_shift  = state inside {S_CMD, S_ADDR, S_DUMMY, S_DATA};
        // A bit period ends at the tick that closes its high phase.
        bit_end   = in_shift && tick && p_out_spi_clk;
        last_bit  = bit_end && (bit_cnt == ((state == S_ADDR) ? 5'd23 : 5'd7));
        accept    = (state == S_IDLE) && p_in_start && (p_in_len != '0);
        byte_done = (state == S_DATA) && last_bit;
        can_load  = !p_out_rxd_vld || p_in_rxd_rdy;
        rx_byte   = {rx_sh[6:0], p_in_spi_miso};
        state_nxt = state;
        case (state)
            S_IDLE:     if (accept) state_nxt = S_CS_SETUP;
            S_CS_SETUP: if (tick) state_nxt = S_CMD;
            S_CMD:      if (last_bit) state_nxt = S_ADDR;
            S_ADDR:
                if (last_bit) begin
`ifdef QSPI_FLASH_RD_FAST_EN
                    state_nxt = S_DUMMY;
`else
                    state_nxt = S_DATA;
`endif
                end
            S_DUMMY:    if (last_bit) state_nxt = S_DATA;
            S_DATA:     if (byte_done && byte_cnt == G_LEN_W'(1)) state_nxt = S_CS_HOLD;
            S_CS_HOLD:  if (tick) state_nxt = S_GAP;
            S_GAP:      if (tick && bit_cnt == 5'd1) state_nxt = S_IDLE;
            default:    state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge p_in_clk or negedge p_in_rstn) begin
        if (!p_in_rstn) state <= S_IDLE;
        else            state <= state_nxt;
    end

    always_ff @(posedge p_in_clk or negedge p_in_rstn) begin
        if (!p_in_rstn) begin
            div_cnt        <= '0;
            bit_cnt        <= '0;
            byte_cnt       <= '0;
            tx_sh          <= '0;
            rx_sh          <= '0;
            pend           <= 1'b0;
            p_out_busy     <= 1'b0;
            p_out_done     <= 1'b0;
            p_out_rxd      <= '0;
            p_out_rxd_vld  <= 1'b0;
            p_out_spi_cs_n <= 1'b1;
            p_out_spi_clk  <= 1'b0;
            p_out_spi_mosi <= 1'b0;
        end else begin
            p_out_spi_cs_n <= (state_nxt == S_IDLE) || (state_nxt == S_GAP);
            p_out_busy     <= (state_nxt != S_IDLE);
            p_out_done     <= (state == S_IDLE && p_in_start && p_in_len == '0) ||
                              (state == S_GAP && tick && bit_cnt == 5'd1);

            if (state == S_IDLE || tick) div_cnt <= '0;
            else if (run)                div_cnt <= div_cnt + DW'(1);

            // bit_cnt counts bits in shift states and half-periods in GAP.
            if (state_nxt != state || last_bit)        bit_cnt <= '0;
            else if (bit_end || (state == S_GAP && tick)) bit_cnt <= bit_cnt + 5'd1;

            if (in_shift && tick) p_out_spi_clk <= ~p_out_spi_clk;

            if (accept) begin
                tx_sh          <= {C_CMD[6:0], p_in_addr};
                p_out_spi_mosi <= C_CMD[7];
                byte_cnt       <= p_in_len;
            end else if (bit_end) begin
                // zeros shift in behind the address, so dummy/data phases drive 0
                tx_sh          <= {tx_sh[29:0], 1'b0};
                p_out_spi_mosi <= tx_sh[30];
            end

            if (bit_end && state == S_DATA) rx_sh <= rx_byte;
            if (byte_done) byte_cnt <= byte_cnt - G_LEN_W'(1);

            if (byte_done && can_load) begin
                p_out_rxd     <= rx_byte;
                p_out_rxd_vld <= 1'b1;
            end else if (byte_done) begin
                pend <= 1'b1;
            end else if (pend && p_in_rxd_rdy) begin
                p_out_rxd     <= rx_sh;
                p_out_rxd_vld <= 1'b1;
                pend          <= 1'b0;
            end else if (p_out_rxd_vld && p_in_rxd_rdy) begin
                p_out_rxd_vld <= 1'b0;
            end
        end
    end

endmodule
